multicycle_control_unit: RTL and testbench

Moore-style control FSM that sequences the shared RV64 datapath (single memory, single ALU, register file, immediate generator) over multiple cycles per instruction. It sits between the instruction register and the datapath muxes/write-enables, decoding the 7-bit opcode and stepping through fetch, decode, execute, memory and writeback. It supports R-type, `ld`, `sd` and conditional branch, and traps on anything else.

---
 rtl/multicycle_control_unit_pkg.sv | 48 ++++
 rtl/multicycle_control_unit_decode.sv | 65 ++++++
 rtl/multicycle_control_unit.sv | 108 ++++++++++
 tb/tb_multicycle_control_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RV64 control path: FSM states,
// major opcodes, ALU operation and ALU operand-B select codes, and the
// packed control vector driven onto the datapath muxes and enables.
package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_ALU_WB    = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_TRAP      = 4'd9
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_decode.sv
// Purely combinational state-to-control-vector map. Any encoding that is
// not a defined state yields an all-zero vector, so no strobe fires while
// the FSM recovers from a corrupted state register.
module control_output_decode
    import multicycle_control_unit_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    // Moore output table: every field defaults to 0, each state raises its own set
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_ALU_WB: begin
                ctrl.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_RS2;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
            end
            ST_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the shared RV64 datapath. Holds the state
// register and next-state logic; outputs come from control_output_decode
// and depend on the state register only.
// Optional feature: define MULTICYCLE_MEM_WAIT_EN to make FETCH, MEM_READ
// and MEM_WRITE hold until mem_ready is high. Without it every memory
// access completes in one cycle and mem_ready is ignored.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_reg;
    state_t state_next;
    logic   mem_done;
    ctrl_t  ctrl;

`ifdef MULTICYCLE_MEM_WAIT_EN
    // Memory states advance only on the edge where the memory reports completion;
    // their strobes stay asserted for the whole hold.
    assign mem_done = mem_ready;
`else
    // Single-cycle memory: the handshake input has no effect.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done = 1'b1;
`endif

    // State register; reset aborts any instruction in flight and restarts at FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; opcode is examined only in DECODE and MEM_ADDR
    always_comb begin
        state_next = ST_FETCH;
        case (state_reg)
            ST_FETCH:     state_next = mem_done ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  state_next = ST_MEM_ADDR;
                    OP_RTYPE:  state_next = ST_EXECUTE;
                    OP_BRANCH: state_next = ST_BRANCH;
                    default:   state_next = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                // An opcode that is neither ld nor sd here is treated as illegal
                case (opcode)
                    OP_LOAD:  state_next = ST_MEM_READ;
                    OP_STORE: state_next = ST_MEM_WRITE;
                    default:  state_next = ST_TRAP;
                endcase
            end
            ST_MEM_READ:  state_next = mem_done ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    state_next = ST_FETCH;
            ST_MEM_WRITE: state_next = mem_done ? ST_FETCH : ST_MEM_WRITE;
            ST_EXECUTE:   state_next = ST_ALU_WB;
            ST_ALU_WB:    state_next = ST_FETCH;
            ST_BRANCH:    state_next = ST_FETCH;
            ST_TRAP:      state_next = ST_TRAP;
            default:      state_next = ST_FETCH;
        endcase
    end

    control_output_decode u_decode (
        .state (state_reg),
        .ctrl  (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign illegal       = ctrl.illegal;
    assign state         = state_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed reset, ld, sd,
// branch, R-type and trap scenarios, then a run of randomly chosen legal
// instructions with garbage opcodes in the states that must ignore them.
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_source, i_or_d;
    logic       mem_read, mem_write, ir_write, mem_to_reg, reg_write;
    logic       alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    state_t exp_seq[$];

    multicycle_control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal       (illegal),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed control word: {pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
    // mem_write, ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal}
    function automatic logic [14:0] dut_ctrl();
        return {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal};
    endfunction

    // Control word each named step must present, taken from the state table
    function automatic logic [14:0] spec_ctrl(input state_t s);
        case (s)
            ST_FETCH:     return 15'b1_0_0_0_1_0_1_0_0_0_01_00_0;
            ST_DECODE:    return 15'b0_0_0_0_0_0_0_0_0_0_10_00_0;
            ST_MEM_ADDR:  return 15'b0_0_0_0_0_0_0_0_0_1_10_00_0;
            ST_MEM_READ:  return 15'b0_0_0_1_1_0_0_0_0_0_00_00_0;
            ST_MEM_WB:    return 15'b0_0_0_0_0_0_0_1_1_0_00_00_0;
            ST_MEM_WRITE: return 15'b0_0_0_1_0_1_0_0_0_0_00_00_0;
            ST_EXECUTE:   return 15'b0_0_0_0_0_0_0_0_0_1_00_10_0;
            ST_ALU_WB:    return 15'b0_0_0_0_0_0_0_0_1_0_00_00_0;
            ST_BRANCH:    return 15'b0_1_1_0_0_0_0_0_0_1_00_01_0;
            ST_TRAP:      return 15'b0_0_0_0_0_0_0_0_0_0_00_00_1;
            default:      return 15'b0;
        endcase
    endfunction

    // Instruction-level model: the sequence of steps an opcode walks through
    task automatic build_seq(input logic [6:0] op);
        exp_seq.delete();
        exp_seq.push_back(ST_FETCH);
        exp_seq.push_back(ST_DECODE);
        if (op == 7'b0000011) begin
            exp_seq.push_back(ST_MEM_ADDR);
            exp_seq.push_back(ST_MEM_READ);
            exp_seq.push_back(ST_MEM_WB);
        end else if (op == 7'b0100011) begin
            exp_seq.push_back(ST_MEM_ADDR);
            exp_seq.push_back(ST_MEM_WRITE);
        end else if (op == 7'b0110011) begin
            exp_seq.push_back(ST_EXECUTE);
            exp_seq.push_back(ST_ALU_WB);
        end else if (op == 7'b1100011) begin
            exp_seq.push_back(ST_BRANCH);
        end
    endtask

    // Run one legal instruction; opcode is valid only where it is sampled
    task automatic run_instr(input string name, input logic [6:0] op);
        int rw = 0, mw = 0, pw = 0, pwc = 0, irw = 0;
        int n_cyc;
        build_seq(op);
        n_cyc = exp_seq.size();
        for (int i = 0; i < n_cyc; i++) begin
            check($sformatf("%s state c%0d", name, i + 1), 32'(state), 32'(exp_seq[i]));
            check($sformatf("%s ctrl c%0d", name, i + 1), 32'(dut_ctrl()), 32'(spec_ctrl(exp_seq[i])));
            rw  += int'(reg_write);
            mw  += int'(mem_write);
            pw  += int'(pc_write);
            pwc += int'(pc_write_cond);
            irw += int'(ir_write);
            if (exp_seq[i] == ST_DECODE || exp_seq[i] == ST_MEM_ADDR)
                opcode = op;
            else
                opcode = 7'($urandom);
            tick();
        end
        check({name, " back to fetch"}, 32'(state), 32'(ST_FETCH));
        check({name, " reg_write pulses"}, 32'(rw),
              32'((op == 7'b0000011 || op == 7'b0110011) ? 1 : 0));
        check({name, " mem_write pulses"}, 32'(mw), 32'((op == 7'b0100011) ? 1 : 0));
        check({name, " pc_write_cond pulses"}, 32'(pwc), 32'((op == 7'b1100011) ? 1 : 0));
        check({name, " pc_write pulses"}, 32'(pw), 32'd1);
        check({name, " ir_write pulses"}, 32'(irw), 32'd1);
    endtask

    logic [6:0] legal_ops[4];

    initial begin
        legal_ops[0] = 7'b0000011;
        legal_ops[1] = 7'b0100011;
        legal_ops[2] = 7'b0110011;
        legal_ops[3] = 7'b1100011;

        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 7'd0;

        // Reset held across edges: FETCH controls present, nothing else
        tick();
        tick();
        check("reset state", 32'(state), 32'(ST_FETCH));
        check("reset ctrl", 32'(dut_ctrl()), 32'(spec_ctrl(ST_FETCH)));
        check("reset illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted in the middle of MEM_ADDR of an ld
        opcode = 7'b0000011;
        tick();
        tick();
        check("mid ld state mem_addr", 32'(state), 32'(ST_MEM_ADDR));
        #2;
        reset = 1'b1;
        #1;
        check("async reset state", 32'(state), 32'(ST_FETCH));
        check("async reset ctrl", 32'(dut_ctrl()), 32'(spec_ctrl(ST_FETCH)));
        tick();
        check("reset hold no writeback", 32'(reg_write), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed instructions
        run_instr("ld", 7'b0000011);
        run_instr("sd", 7'b0100011);
        run_instr("beq", 7'b1100011);
        run_instr("add", 7'b0110011);

        // Random legal instruction stream
        for (int k = 0; k < 40; k++) begin
            logic [6:0] op;
            op = legal_ops[$urandom_range(0, 3)];
            run_instr($sformatf("rnd%0d", k), op);
        end

        // Illegal opcode: TRAP from cycle 3, sticky, no strobes
        check("trap c1 state", 32'(state), 32'(ST_FETCH));
        opcode = 7'($urandom);
        tick();
        check("trap c2 state", 32'(state), 32'(ST_DECODE));
        opcode = 7'b1111111;
        tick();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("trap hold state %0d", i), 32'(state), 32'(ST_TRAP));
            check($sformatf("trap hold ctrl %0d", i), 32'(dut_ctrl()), 32'(spec_ctrl(ST_TRAP)));
            opcode = (i % 2 == 0) ? 7'b0110011 : 7'($urandom);
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        check("trap cleared state", 32'(state), 32'(ST_FETCH));
        check("trap cleared illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_instr("post trap add", 7'b0110011);

`ifdef MULTICYCLE_MEM_WAIT_EN
        // ld with three wait cycles in MEM_READ: eight cycles, one reg_write
        begin
            state_t wseq[$];
            int rw = 0;
            wseq = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ, ST_MEM_READ,
                     ST_MEM_READ, ST_MEM_READ, ST_MEM_WB};
            for (int i = 0; i < 8; i++) begin
                check($sformatf("wait ld state c%0d", i + 1), 32'(state), 32'(wseq[i]));
                check($sformatf("wait ld ctrl c%0d", i + 1), 32'(dut_ctrl()), 32'(spec_ctrl(wseq[i])));
                rw += int'(reg_write);
                opcode    = 7'b0000011;
                mem_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
                tick();
            end
            mem_ready = 1'b1;
            check("wait ld back to fetch", 32'(state), 32'(ST_FETCH));
            check("wait ld reg_write pulses", 32'(rw), 32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
